// File: rtl/forward_select_unit.sv
// Operand forwarding select with load-use stall; zero-latency combinational select from a registered tag pipeline.
// Optional counters are built only when FWD_STATS_EN is defined; stall inserts an EX bubble and ignores issue.
module forward_select_unit #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int SRCS   = 4,
  parameter int REG_AW = 5,
  parameter int SW     = $clog2(STAGES*LANES+1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LANES-1:0]                iss_valid,
  input  logic [LANES*REG_AW-1:0]         iss_rd,
  input  logic [LANES-1:0]                iss_load,
  input  logic                            adv,
  input  logic                            flush,
  input  logic [SRCS-1:0]                 src_valid,
  input  logic [SRCS*REG_AW-1:0]          src_rs,
  input  logic [SRCS*WIDTH-1:0]           src_rf_data,
  input  logic [STAGES*LANES*WIDTH-1:0]   stg_data,
  input  logic [STAGES*LANES-1:0]         stg_ok,
  output logic [SRCS*SW-1:0]              fwd_sel,
  output logic [SRCS*WIDTH-1:0]           fwd_data,
  output logic                            stall,
  output logic [31:0]                     stat_fwd_cnt,
  output logic [31:0]                     stat_stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              load;
  } tag_t;

  typedef enum logic {RUN, HOLD} state_t;

  tag_t [STAGES-1:0][LANES-1:0] tag_q, tag_d;
  state_t                       state_q, state_d;
  logic [SRCS-1:0]              win_ok;

  // Later hits in the scan overwrite earlier ones, so scan from lowest to highest priority.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = src_rf_data;
    win_ok   = '1;
    for (int s = 0; s < SRCS; s++) begin
      for (int st = STAGES-1; st >= 0; st--) begin
        for (int ln = 0; ln < LANES; ln++) begin
          if (tag_q[st][ln].vld && src_valid[s] &&
              (tag_q[st][ln].rd == src_rs[s*REG_AW +: REG_AW]) &&
              (tag_q[st][ln].rd != '0)) begin
            fwd_sel[s*SW +: SW]        = SW'(st*LANES + ln + 1);
            fwd_data[s*WIDTH +: WIDTH] = stg_data[(st*LANES + ln)*WIDTH +: WIDTH];
            win_ok[s]                  = stg_ok[st*LANES + ln];
          end
        end
      end
    end
    stall = ~&win_ok;
  end

  always_comb begin
    tag_d = tag_q;
    if (flush) begin
      tag_d = '0;
    end else if (adv) begin
      for (int st = STAGES-1; st >= 1; st--) begin
        tag_d[st] = tag_q[st-1];
      end
      for (int ln = 0; ln < LANES; ln++) begin
        if (stall) begin
          tag_d[0][ln] = '0;
        end else begin
          tag_d[0][ln].vld  = iss_valid[ln];
          tag_d[0][ln].rd   = iss_rd[ln*REG_AW +: REG_AW];
          tag_d[0][ln].load = iss_load[ln] & iss_valid[ln];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (!flush && stall) state_d = HOLD;
      HOLD: if (flush || !stall) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      state_q <= RUN;
    end else begin
      tag_q   <= tag_d;
      state_q <= state_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (adv && !stall && (|fwd_sel) && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    if ((state_q == HOLD) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

  // Invariants: a load flag never outlives its valid bit; an unflushed stall always lands in HOLD.
  for (genvar gs = 0; gs < STAGES; gs++) begin : g_inv_st
    for (genvar gl = 0; gl < LANES; gl++) begin : g_inv_ln
      a_load_vld: assert property (@(posedge clk) disable iff (!rst_n)
        !(tag_q[gs][gl].load && !tag_q[gs][gl].vld));
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (stall && !flush) |=> (state_q == HOLD));

endmodule
